uart_rx_fifo: RTL and testbench

Parametrised UART receiver that succeeds the fixed 8N1 receive path in the UART top. It oversamples RsRx with a per-bit clock counter and supports configurable data width, parity and stop bits. It detects parity, framing and overrun errors, and buffers good frames in a small first-word-fall-through FIFO. Data is presented to downstream image-processing logic over a valid/ready handshake.

---
 rtl/uart_rx_fifo.sv | 118 +++++++++++
 tb/tb_uart_rx_fifo.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling UART receiver with parity/framing/overrun detection feeding a FWFT frame FIFO
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 32,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 RsRx,
    output logic [DATA_BITS-1:0] Rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int HALF = CLKS_PER_BIT / 2;

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, PUSH} state_t;

    state_t               state;
    logic [1:0]           sync;
    logic                 rxs, rxs_d;
    logic [CW-1:0]        cnt;
    logic [3:0]           bit_n;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bad, stop_bad;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [AW:0]          count;
    logic                 tick, pop, full, push_ok;

    assign rxs      = sync[1];
    assign tick     = cnt == CW'(CLKS_PER_BIT - 1);
    assign rx_valid = count != '0;
    assign pop      = rx_valid && rx_ready;
    assign full     = count == (AW+1)'(FIFO_DEPTH);
    assign push_ok  = state == PUSH && !stop_bad && !par_bad && (!full || pop);
    assign Rx_data  = mem[rd_ptr];
    assign busy     = state != IDLE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync       <= 2'b11;
            rxs_d      <= 1'b1;
            state      <= IDLE;
            cnt        <= '0;
            bit_n      <= '0;
            shreg      <= '0;
            par_bad    <= 1'b0;
            stop_bad   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            sync       <= {sync[0], RsRx};
            rxs_d      <= rxs;
            frame_err  <= state == PUSH && stop_bad;
            parity_err <= state == PUSH && !stop_bad && par_bad;
            overrun    <= state == PUSH && !stop_bad && !par_bad && full && !pop;
            cnt        <= tick ? '0 : cnt + 1'b1;
            case (state)
                IDLE: if (rxs_d && !rxs) begin
                    state    <= START;
                    cnt      <= '0;
                    bit_n    <= '0;
                    par_bad  <= 1'b0;
                    stop_bad <= 1'b0;
                end
                START: if (cnt == CW'(HALF - 1)) begin
                    cnt   <= '0;
                    state <= rxs ? IDLE : DATA;
                end
                DATA: if (tick) begin
                    shreg <= {rxs, shreg[DATA_BITS-1:1]};
                    bit_n <= bit_n + 1'b1;
                    if (bit_n == 4'(DATA_BITS - 1)) begin
                        bit_n <= '0;
                        state <= PARITY != 0 ? PAR : STOP;
                    end
                end
                // odd parity wants data^p == 1, even wants 0
                PAR: if (tick) begin
                    par_bad <= (^shreg) ^ rxs ^ (PARITY == 1);
                    state   <= STOP;
                end
                STOP: if (tick) begin
                    stop_bad <= stop_bad || !rxs;
                    bit_n    <= bit_n + 1'b1;
                    if (bit_n == 4'(STOP_BITS - 1)) state <= PUSH;
                end
                PUSH: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= shreg;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: three differently configured receivers driven with directed and random frames against a queue model
module tb_uart_rx_fifo;
    localparam int NI = 3;

    logic          clk = 0;
    logic          rst = 1;
    logic [NI-1:0] rs_rx, rdy, valid, perr, ferr, ovr, bsy;
    logic [7:0]    rxd0, rxd1;
    logic [6:0]    rxd2;
    logic [8:0]    rxd_a, last_pop, prev_data;
    logic [8:0]    q [$];
    int            act = 0, cyc = 0, checks = 0, failures = 0, pops = 0, rise_cyc = 0;
    int            exp_perr = 0, exp_ferr = 0, exp_ovr = 0, got_perr = 0, got_ferr = 0, got_ovr = 0;
    bit            rand_rdy = 0, prev_valid = 0, prev_hold = 0, prev_flag = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_fifo u0 (.clk(clk), .rst(rst), .RsRx(rs_rx[0]), .Rx_data(rxd0), .rx_valid(valid[0]), .rx_ready(rdy[0]),
                     .parity_err(perr[0]), .frame_err(ferr[0]), .overrun(ovr[0]), .busy(bsy[0]));
    uart_rx_fifo #(.CLKS_PER_BIT(16), .PARITY(2)) u1 (.clk(clk), .rst(rst), .RsRx(rs_rx[1]), .Rx_data(rxd1),
                     .rx_valid(valid[1]), .rx_ready(rdy[1]), .parity_err(perr[1]), .frame_err(ferr[1]),
                     .overrun(ovr[1]), .busy(bsy[1]));
    uart_rx_fifo #(.CLKS_PER_BIT(12), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(2)) u2 (.clk(clk),
                     .rst(rst), .RsRx(rs_rx[2]), .Rx_data(rxd2), .rx_valid(valid[2]), .rx_ready(rdy[2]),
                     .parity_err(perr[2]), .frame_err(ferr[2]), .overrun(ovr[2]), .busy(bsy[2]));

    always_comb rxd_a = act == 0 ? {1'b0, rxd0} : act == 1 ? {1'b0, rxd1} : {2'b0, rxd2};

    function automatic int cpb(input int i); return i == 0 ? 32 : i == 1 ? 16 : 12; endfunction
    function automatic int dbw(input int i); return i == 2 ? 7 : 8; endfunction
    function automatic int pmode(input int i); return i == 0 ? 0 : i == 1 ? 2 : 1; endfunction
    function automatic int sbw(input int i); return i == 2 ? 2 : 1; endfunction
    function automatic int dep(input int i); return i == 2 ? 2 : 4; endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    // Model: the active receiver's FIFO is a queue; the head must show whenever rx_valid is high
    always @(negedge clk) begin
        if (rst) begin
            if (prev_hold) chk("hold_stable", rxd_a, prev_data);
            if (valid[act]) begin
                if (q.size() == 0) chk("spurious_valid", valid[act], 0);
                else begin
                    chk("head", rxd_a, q[0]);
                    if (rdy[act]) begin
                        last_pop = q.pop_front();
                        pops++;
                    end
                end
                if (!prev_valid) rise_cyc = cyc;
            end
            if (perr[act] | ferr[act] | ovr[act]) chk("one_flag", $countones({perr[act], ferr[act], ovr[act]}), 1);
            if (prev_flag) chk("pulse_width", {perr[act], ferr[act], ovr[act]}, 0);
            got_perr += int'(perr[act]);
            got_ferr += int'(ferr[act]);
            got_ovr  += int'(ovr[act]);
        end
        prev_valid = valid[act];
        prev_hold  = valid[act] && !rdy[act];
        prev_data  = rxd_a;
        prev_flag  = perr[act] | ferr[act] | ovr[act];
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) rdy[act] = $urandom_range(0, 3) != 0;
    endtask

    task automatic drive_bit(input logic b);
        rs_rx[act] = b;
        repeat (cpb(act)) tick();
    endtask

    task automatic send_frame(input logic [8:0] d, input bit bad_par, input logic [1:0] stop_low, input int low_tail);
        int         db = dbw(act), sb = sbw(act), pm = pmode(act);
        logic [8:0] dm = d & 9'((1 << db) - 1);
        logic [1:0] sl = stop_low & (sb == 2 ? 2'b11 : 2'b01);
        logic       p  = (^dm) ^ (pm == 1) ^ bad_par;
        bit         tail_busy = 0;
        if (sl != 0) exp_ferr++;
        else if (bad_par && pm != 0) exp_perr++;
        else if (q.size() >= dep(act) && !rdy[act]) exp_ovr++;
        else q.push_back(dm);
        drive_bit(1'b0);
        for (int i = 0; i < db; i++) drive_bit(dm[i]);
        if (pm != 0) drive_bit(p);
        for (int i = 0; i < sb; i++) drive_bit(!sl[i]);
        repeat (low_tail) begin
            tick();
            tail_busy |= bsy[act];
        end
        if (low_tail > 0) chk("stuck_low_busy", tail_busy, 0);
        rs_rx[act] = 1'b1;
        repeat (cpb(act) + 8) tick();
        chk("busy_idle", bsy[act], 0);
        chk("perr_count", got_perr, exp_perr);
        chk("ferr_count", got_ferr, exp_ferr);
        chk("ovr_count", got_ovr, exp_ovr);
        chk("valid_vs_model", valid[act], q.size() != 0);
    endtask

    task automatic reset_mid(input logic [8:0] d);
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(d[i]);
        chk("busy_mid", bsy[act], 1);
        rst = 0;
        #1;
        chk("mid_valid", valid[act], 0);
        chk("mid_busy", bsy[act], 0);
        chk("mid_flags", {perr[act], ferr[act], ovr[act]}, 0);
        chk("mid_data", rxd_a, 0);
        q.delete();
        rs_rx[act] = 1'b1;
        repeat (3) tick();
        rst = 1;
        repeat (4) tick();
    endtask

    initial begin
        int t0, lat;
        bit seen;
        rs_rx = '1;
        rdy   = '1;
        #2 rst = 0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            chk("rst_valid", valid[i], 0);
            chk("rst_busy", bsy[i], 0);
            chk("rst_flags", {perr[i], ferr[i], ovr[i]}, 0);
        end
        chk("rst_data", {rxd0, rxd1, rxd2}, 0);
        rst = 1;
        repeat (4) tick();

        act = 0;
        for (int i = 1; i <= 4; i++) begin
            t0 = cyc;
            send_frame(9'(i), 0, 2'b00, 0);
            chk("pop_order", last_pop, 9'(i));
            lat = rise_cyc - t0;
            if (i == 1) chk("valid_latency", (lat >= 306 && lat <= 312) ? 308 : lat, 308);
        end
        chk("pops_basic", pops, 4);

        seen = 0;
        rs_rx[0] = 1'b0;
        repeat (10) begin tick(); seen |= bsy[0]; end
        rs_rx[0] = 1'b1;
        repeat (40) begin tick(); seen |= bsy[0]; end
        chk("false_start_busy_seen", seen, 1);
        chk("false_start_busy_end", bsy[0], 0);
        chk("false_start_valid", valid[0], 0);
        chk("false_start_flags", got_perr + got_ferr + got_ovr, 0);

        send_frame(9'h3C, 0, 2'b01, 96);
        chk("ferr_total", got_ferr, 1);
        send_frame(9'h55, 0, 2'b00, 0);
        chk("after_ferr_pop", last_pop, 9'h55);

        rdy[0] = 1'b0;
        pops = 0;
        for (int i = 0; i < 5; i++) send_frame(9'h10 + 9'(i), 0, 2'b00, 0);
        chk("ovr_total", got_ovr, 1);
        chk("ovr_head", rxd_a, 9'h10);
        rdy[0] = 1'b1;
        repeat (12) tick();
        chk("ovr_drain_pops", pops, 4);
        chk("ovr_last_pop", last_pop, 9'h13);
        chk("ovr_drained", valid[0], 0);

        reset_mid(9'h7E);
        send_frame(9'h7E, 0, 2'b00, 0);
        chk("after_reset_pop", last_pop, 9'h7E);

        act = 1;
        send_frame(9'hA5, 0, 2'b00, 0);
        chk("even_par_pop", last_pop, 9'hA5);
        send_frame(9'hA5, 1, 2'b00, 0);
        chk("perr_total", got_perr, 1);

        act = 2;
        rdy[2] = 1'b0;
        send_frame(9'h41, 0, 2'b00, 0);
        chk("held_before_reset", valid[2], 1);
        reset_mid(9'h41);
        rdy[2] = 1'b1;
        send_frame(9'h41, 0, 2'b00, 0);
        chk("d7s2_pop", last_pop, 9'h41);

        for (int a = 0; a < NI; a++) begin
            act = a;
            rand_rdy = 1;
            for (int n = 0; n < 20; n++)
                send_frame(9'($urandom_range(0, 511)), $urandom_range(0, 4) == 0,
                           $urandom_range(0, 4) == 0 ? 2'($urandom_range(1, 3)) : 2'b00, 0);
            rand_rdy = 0;
            rdy[a] = 1'b1;
            repeat (20) tick();
            chk("random_drained", valid[a], 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
